pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and control-flow unit for the lab CPU. It drives the 16-bit address into the combinational instruction ROM and decodes the flow-control opcodes of the returned 28-bit word: `JMP`, `CALL`, `RET`, `BLE` and timed `NOP`. It maintains a hardware return-address stack. It gives the register/ALU datapath a stall signal so that datapath only commits an instruction when the sequencer is running.

## Interface
Parameters:
- STACK_DEPTH, 8: number of return-address entries (power of two, 2..16).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; one clock, one reset domain.
- iInstruction  in  28  ROM output for the current oAddress; same-cycle (combinational ROM).
- iOperandA  in  16  register-file read of field [15:8], supplied by datapath.
- iOperandB  in  16  register-file read of field [7:0], supplied by datapath.
- oAddress  out  16  current program counter to ROM.
- oStall  out  1  1 = datapath must not commit the presented instruction.
- oDepth  out  5  number of valid stack entries (0..STACK_DEPTH).
- oOverflow  out  1  sticky: `CALL` attempted with stack full.
- oUnderflow  out  1  sticky: `RET` attempted with stack empty.

## Operation
- Fields: opcode = iInstruction[27:24], using the values in the shared definitions header. Target = iInstruction[23:16], zero-extended to 16 bits. NOP count N = iInstruction[23:0].
- States: RUN, WAIT, FAULT.
- In RUN, the instruction at oAddress executes in the current cycle, and next-PC is chosen as follows:
  - `JMP`: target.
  - `CALL`: push oAddress+1, then target. If the stack is full, set oOverflow and go to FAULT; PC is held and nothing is pushed.
  - `RET`: pop, then PC = popped value. If the stack is empty, set oUnderflow and go to FAULT; PC is held.
  - `BLE`: target if iOperandA <= iOperandB (16-bit unsigned compare), else oAddress+1.
  - `NOP`: if N = 0, oAddress+1. If N > 0, load the 24-bit counter with N, hold PC and go to WAIT.
  - Any other opcode (datapath ops, `LED`, `WVM`, ...): oAddress+1.
- In WAIT, oStall = 1 and PC is held. The counter decrements every cycle. In the cycle the counter equals 1, next PC = oAddress+1 and the state returns to RUN.
- FAULT is terminal. oStall = 1 and PC, stack and flags are frozen; only Reset leaves FAULT.
- PC increment wraps: 16'hFFFF+1 = 16'h0000.
- The stack is LIFO with depth STACK_DEPTH. oDepth counts entries. Stack contents are not cleared on reset, but oDepth is reset to 0.
- oStall = 0 in RUN, 1 in WAIT and FAULT.

## Timing
- Reset values: oAddress = 0, state RUN, oDepth = 0, oOverflow = 0, oUnderflow = 0, counter = 0, oStall = 0.
- Reset has priority over every instruction, including an active WAIT or FAULT. The cycle after Reset deasserts presents address 0.
- Non-NOP instructions take 1 cycle; the new PC is visible on oAddress the cycle after the instruction is presented.
- A `NOP` with count N occupies N+1 cycles at the same address: 1 RUN cycle (oStall = 0) plus N WAIT cycles (oStall = 1).
- A `BLE` samples iOperandA/B in its RUN cycle. A datapath write committed at the preceding edge (for example, an `ADD` in the prior cycle) must already be visible; no forwarding is needed from the sequencer.
- `CALL` pushes and `RET` pops at the same edge that updates PC. A `RET` directly after a `CALL` returns to the `CALL` address+1.
- Sticky flags assert at the edge that enters FAULT and remain until Reset.

## Test plan
- Reset, then a straight-line program of non-flow opcodes → oAddress = 0, 1, 2, 3 on consecutive cycles; oStall = 0 throughout.
- `NOP` with N = 3 at address 0 → oAddress stays 0 for 4 cycles, oStall = 0,1,1,1, then oAddress = 1. Also `NOP` with N = 0 → advances after 1 cycle.
- `CALL` 17 at address 5; address 17 = `RET` → oAddress 5, 17, 6; oDepth goes 0, 1, 0. Nested `CALL` to depth 8 → oDepth = 8. A ninth `CALL` → oOverflow = 1, oStall = 1, PC frozen until Reset.
- `BLE` 19 at address 19 with A = 0x00FE, B = 0x00FF, then A = 0x00FF, then A = 0x0100 → next PC = 19, 19, 20. Also A = 0xFFFF, B = 0x0001 → 20 (unsigned compare).
- `RET` with oDepth = 0 → oUnderflow = 1, FAULT, oAddress held. Assert Reset mid-WAIT (N = 4000) and in FAULT → next cycle oAddress = 0, flags clear, oStall = 0.
- PC = 0xFFFF with a non-flow opcode → next oAddress = 0x0000. `JMP` 15 executed repeatedly at address 16 → PC alternates 15/16 as programmed.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter, flow-control decode and return-address stack
// for the lab CPU; drives the combinational instruction ROM.
package pc_sequencer_pkg;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_CALL = 4'h2;
    localparam logic [3:0] OP_RET  = 4'h3;
    localparam logic [3:0] OP_BLE  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_LED  = 4'h6;
    localparam logic [3:0] OP_WVM  = 4'h7;
endpackage

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [27:0] iInstruction,
    input  logic [15:0] iOperandA,
    input  logic [15:0] iOperandB,
    output logic [15:0] oAddress,
    output logic        oStall,
    output logic [4:0]  oDepth,
    output logic        oOverflow,
    output logic        oUnderflow
);
    localparam int AW = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_FAULT
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n, pc_inc;
    logic [4:0]  depth, depth_n, depth_m1;
    logic [23:0] cnt, cnt_n;
    logic        ovf, ovf_n, unf, unf_n;
    logic        push, full, empty;
    logic [15:0] stack [STACK_DEPTH];

    logic [3:0]  op;
    logic [15:0] target;
    logic [23:0] nop_n;

    assign op       = iInstruction[27:24];
    assign target   = {8'h00, iInstruction[23:16]};
    assign nop_n    = iInstruction[23:0];
    assign pc_inc   = pc + 16'd1;
    assign depth_m1 = depth - 5'd1;
    assign full     = (depth == 5'(STACK_DEPTH));
    assign empty    = (depth == 5'd0);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        depth_n = depth;
        cnt_n   = cnt;
        ovf_n   = ovf;
        unf_n   = unf;
        push    = 1'b0;
        unique case (state)
            S_RUN: begin
                case (op)
                    OP_JMP: pc_n = target;
                    OP_CALL: begin
                        if (full) begin
                            ovf_n   = 1'b1;
                            state_n = S_FAULT;
                        end else begin
                            push    = 1'b1;
                            depth_n = depth + 5'd1;
                            pc_n    = target;
                        end
                    end
                    OP_RET: begin
                        if (empty) begin
                            unf_n   = 1'b1;
                            state_n = S_FAULT;
                        end else begin
                            depth_n = depth_m1;
                            pc_n    = stack[depth_m1[AW-1:0]];
                        end
                    end
                    OP_BLE: pc_n = (iOperandA <= iOperandB) ? target : pc_inc;
                    OP_NOP: begin
                        if (nop_n == 24'd0) begin
                            pc_n = pc_inc;
                        end else begin
                            cnt_n   = nop_n;
                            state_n = S_WAIT;
                        end
                    end
                    default: pc_n = pc_inc;
                endcase
            end
            S_WAIT: begin
                // Last wait cycle is the one where the counter reads 1.
                if (cnt == 24'd1) begin
                    pc_n    = pc_inc;
                    cnt_n   = 24'd0;
                    state_n = S_RUN;
                end else begin
                    cnt_n = cnt - 24'd1;
                end
            end
            S_FAULT: begin
            end
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_RUN;
            pc    <= 16'h0000;
            depth <= 5'd0;
            cnt   <= 24'd0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            depth <= depth_n;
            cnt   <= cnt_n;
            ovf   <= ovf_n;
            unf   <= unf_n;
        end
    end

    // Stack RAM keeps its contents across reset; only the depth is cleared.
    always_ff @(posedge Clock) begin
        if (push && !Reset) begin
            stack[depth[AW-1:0]] <= pc_inc;
        end
    end

    assign oAddress   = pc;
    assign oStall     = (state != S_RUN);
    assign oDepth     = depth;
    assign oOverflow  = ovf;
    assign oUnderflow = unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed ROM programs,
// expected per-cycle outputs queued and compared by a monitor.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [27:0] iInstruction;
    logic [15:0] iOperandA = 16'h0000;
    logic [15:0] iOperandB = 16'h0000;
    logic [15:0] oAddress;
    logic        oStall;
    logic [4:0]  oDepth;
    logic        oOverflow;
    logic        oUnderflow;

    logic [27:0] rom [65536];

    pc_sequencer #(.STACK_DEPTH(8)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iInstruction (iInstruction),
        .iOperandA    (iOperandA),
        .iOperandB    (iOperandB),
        .oAddress     (oAddress),
        .oStall       (oStall),
        .oDepth       (oDepth),
        .oOverflow    (oOverflow),
        .oUnderflow   (oUnderflow)
    );

    assign iInstruction = rom[oAddress];

    always #5 Clock = ~Clock;

    typedef struct {
        int          tag;
        logic [15:0] a;
        logic        s;
        logic [4:0]  d;
        logic        o;
        logic        u;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [27:0] ins(logic [3:0] op, logic [23:0] f);
        return {op, f};
    endfunction

    task automatic clr();
        for (int i = 0; i < 65536; i++) rom[i] = ins(OP_ADD, 24'h000102);
    endtask

    task automatic rst();
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic chk(int tag, logic [15:0] a, logic s,
                       logic [4:0] d, logic o, logic u);
        exp_t e;
        e.tag = tag;
        e.a   = a;
        e.s   = s;
        e.d   = d;
        e.o   = o;
        e.u   = u;
        q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (oAddress !== mon_e.a || oStall !== mon_e.s ||
                oDepth !== mon_e.d || oOverflow !== mon_e.o ||
                oUnderflow !== mon_e.u) begin
                errors++;
                $display("FAIL step%0d: got addr=%h stall=%b depth=%0d ovf=%b unf=%b, want addr=%h stall=%b depth=%0d ovf=%b unf=%b",
                         mon_e.tag, oAddress, oStall, oDepth, oOverflow,
                         oUnderflow, mon_e.a, mon_e.s, mon_e.d, mon_e.o,
                         mon_e.u);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        clr();
        // straight line
        rst();
        for (int i = 0; i < 4; i++) chk(100 + i, 16'(i), 0, 0, 0, 0);

        // NOP 3 then NOP 0
        clr();
        rom[0] = ins(OP_NOP, 24'd3);
        rom[1] = ins(OP_NOP, 24'd0);
        rst();
        chk(200, 0, 0, 0, 0, 0);
        chk(201, 0, 1, 0, 0, 0);
        chk(202, 0, 1, 0, 0, 0);
        chk(203, 0, 1, 0, 0, 0);
        chk(204, 1, 0, 0, 0, 0);
        chk(205, 2, 0, 0, 0, 0);

        // CALL 17 / RET
        clr();
        rom[5]  = ins(OP_CALL, 24'h110000);
        rom[17] = ins(OP_RET, 24'h0);
        rst();
        for (int i = 0; i < 5; i++) chk(300 + i, 16'(i), 0, 0, 0, 0);
        chk(305, 5, 0, 0, 0, 0);
        chk(306, 17, 0, 1, 0, 0);
        chk(307, 6, 0, 0, 0, 0);
        chk(308, 7, 0, 0, 0, 0);

        // nested CALL to full, ninth overflows
        clr();
        rom[0] = ins(OP_JMP, 24'h200000);
        for (int i = 32; i <= 40; i++) rom[i] = ins(OP_CALL, {8'(i + 1), 16'h0});
        rst();
        chk(400, 0, 0, 0, 0, 0);
        chk(401, 32, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) chk(401 + k, 16'(32 + k), 0, 5'(k), 0, 0);
        chk(410, 40, 1, 8, 1, 0);
        chk(411, 40, 1, 8, 1, 0);
        chk(412, 40, 1, 8, 1, 0);

        // BLE
        clr();
        rom[0]  = ins(OP_JMP, 24'h130000);
        rom[19] = ins(OP_BLE, 24'h130000);
        rst();
        iOperandB = 16'h00FF;
        iOperandA = 16'h00FE;
        chk(500, 0, 0, 0, 0, 0);
        chk(501, 19, 0, 0, 0, 0);
        iOperandA = 16'h00FF;
        chk(502, 19, 0, 0, 0, 0);
        iOperandA = 16'h0100;
        chk(503, 19, 0, 0, 0, 0);
        chk(504, 20, 0, 0, 0, 0);
        iOperandA = 16'hFFFF;
        iOperandB = 16'h0001;
        rst();
        chk(505, 0, 0, 0, 0, 0);
        chk(506, 19, 0, 0, 0, 0);
        chk(507, 20, 0, 0, 0, 0);

        // RET underflow, reset out of FAULT and out of WAIT
        clr();
        rom[0] = ins(OP_RET, 24'h0);
        rst();
        chk(600, 0, 0, 0, 0, 0);
        chk(601, 0, 1, 0, 0, 1);
        chk(602, 0, 1, 0, 0, 1);
        rom[0] = ins(OP_NOP, 24'd4000);
        rst();
        chk(603, 0, 0, 0, 0, 0);
        chk(604, 0, 1, 0, 0, 0);
        chk(605, 0, 1, 0, 0, 0);
        rom[0] = ins(OP_ADD, 24'h0);
        rst();
        chk(606, 0, 0, 0, 0, 0);
        chk(607, 1, 0, 0, 0, 0);

        // JMP loop
        clr();
        rom[0]  = ins(OP_JMP, 24'h100000);
        rom[16] = ins(OP_JMP, 24'h0F0000);
        rst();
        chk(700, 0, 0, 0, 0, 0);
        chk(701, 16, 0, 0, 0, 0);
        chk(702, 15, 0, 0, 0, 0);
        chk(703, 16, 0, 0, 0, 0);
        chk(704, 15, 0, 0, 0, 0);
        chk(705, 16, 0, 0, 0, 0);

        // PC wrap at 0xFFFF
        clr();
        rst();
        chk(800, 0, 0, 0, 0, 0);
        repeat (65534) @(posedge Clock);
        #1;
        chk(801, 16'hFFFF, 0, 0, 0, 0);
        chk(802, 16'h0000, 0, 0, 0, 0);

        @(posedge Clock);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
